// File: rtl/speed_round_ctrl.sv
// speed_round_ctrl
// ----------------
// Sequencer for the tug-of-war speed round. After a start pulse it runs a
// get-ready phase (ARM), opens the push-counting window (ROUND), waits two
// cycles for the push counter's registered compare (SETTLE), samples the
// counter's verdict (DECIDE), and then sends a one-cycle clear to the counter
// (EXIT) before returning to IDLE.
//
// Optional feature: define SPEED_SUDDEN_DEATH_EN to enable sudden death.
// With it, the first tie of a game is not reported. The block pulses
// speed_exit and reruns the ROUND window once, skipping ARM and IDLE. A
// second tie is then reported as 11.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   start         one-cycle start request (honoured only in IDLE)
//   abort         one-cycle cancel (honoured in ARM, ROUND, SETTLE)
//   speed_right   push counter verdict: right ahead (sampled in DECIDE)
//   speed_tie     push counter verdict: equal counts (sampled in DECIDE)
//   speed_round   high while pushes are counted
//   speed_exit    one-cycle clear pulse to the push counter
//   countdown     remaining ticks of the ARM/ROUND phase, otherwise 0
//   busy          high in every state except IDLE
//   result        00 none, 01 left, 10 right, 11 tie; held until next decision
//   result_valid  one-cycle pulse when result updates
//   state_dbg     current FSM state (debug observation)
//
// Pulse semantics: start, abort, speed_exit and result_valid are single-cycle
// strobes with no back-pressure. A strobe is consumed on the clock edge where
// it is high. result_valid is only ever high in the EXIT cycle. In that cycle
// it coincides with speed_exit, and result already holds the new value.

module speed_round_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int ARM_TICKS   = 3,
  parameter int ROUND_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       speed_right,
  input  logic       speed_tie,
  output logic       speed_round,
  output logic       speed_exit,
  output logic [3:0] countdown,
  output logic       busy,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [2:0] state_dbg
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_ROUND  = 3'd2,
    S_SETTLE = 3'd3,
    S_DECIDE = 3'd4,
    S_EXIT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]  countdown_q, countdown_d;
  logic [1:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        speed_round_q, speed_exit_q, busy_q;
  logic        tick;
`ifdef SPEED_SUDDEN_DEATH_EN
  logic        retry_q, retry_d;
  logic        rerun_q, rerun_d;  // EXIT should loop back into ROUND
`endif

  assign tick = (cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    countdown_d    = countdown_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
`ifdef SPEED_SUDDEN_DEATH_EN
    retry_d        = retry_q;
    rerun_d        = rerun_q;
`endif

    case (state_q)
      S_IDLE: begin
        // abort beats start when both arrive in the same cycle
        if (start && !abort) begin
          cnt_d = '0;
          if (ARM_TICKS == 0) begin
            state_d     = S_ROUND;
            countdown_d = 4'(ROUND_TICKS);
          end else begin
            state_d     = S_ARM;
            countdown_d = 4'(ARM_TICKS);
          end
        end
      end

      S_ARM: begin
        if (abort) begin
          state_d     = S_EXIT;
          countdown_d = 4'd0;
          cnt_d       = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (countdown_q == 4'd1) begin
            state_d     = S_ROUND;
            countdown_d = 4'(ROUND_TICKS);
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_ROUND: begin
        if (abort) begin
          state_d     = S_EXIT;
          countdown_d = 4'd0;
          cnt_d       = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (countdown_q == 4'd1) begin
            state_d     = S_SETTLE;
            countdown_d = 4'd0;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      // The tick counter enters SETTLE at 0 and times the two settle cycles.
      S_SETTLE: begin
        if (abort) begin
          state_d = S_EXIT;
          cnt_d   = '0;
        end else if (cnt_q == TW'(1)) begin
          state_d = S_DECIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_DECIDE: begin
        state_d = S_EXIT;
`ifdef SPEED_SUDDEN_DEATH_EN
        if (!speed_right && speed_tie && !retry_q) begin
          retry_d = 1'b1;
          rerun_d = 1'b1;
        end else
`endif
        begin
          result_valid_d = 1'b1;
          if (speed_right)    result_d = 2'b10;
          else if (speed_tie) result_d = 2'b11;
          else                result_d = 2'b01;
        end
      end

      S_EXIT: begin
`ifdef SPEED_SUDDEN_DEATH_EN
        if (rerun_q) begin
          state_d     = S_ROUND;
          countdown_d = 4'(ROUND_TICKS);
          cnt_d       = '0;
          rerun_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: begin
        state_d     = S_IDLE;
        countdown_d = 4'd0;
        cnt_d       = '0;
      end
    endcase

`ifdef SPEED_SUDDEN_DEATH_EN
    if (state_d == S_IDLE) retry_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      countdown_q    <= 4'd0;
      result_q       <= 2'b00;
      result_valid_q <= 1'b0;
      speed_round_q  <= 1'b0;
      speed_exit_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      countdown_q    <= countdown_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      // Status outputs are registered from the next state so that they
      // change on the same edge as the state register.
      speed_round_q  <= (state_d == S_ROUND);
      speed_exit_q   <= (state_d == S_EXIT);
      busy_q         <= (state_d != S_IDLE);
    end
  end

`ifdef SPEED_SUDDEN_DEATH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_q <= 1'b0;
      rerun_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
      rerun_q <= rerun_d;
    end
  end
`endif

  assign speed_round  = speed_round_q;
  assign speed_exit   = speed_exit_q;
  assign countdown    = countdown_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Bench for speed_round_ctrl with TICK_DIV=4, ARM_TICKS=2, ROUND_TICKS=3.
// The driver issues directed rounds and pushes the expected responses into
// queues. A negedge monitor pops and compares them whenever the DUT pulses
// speed_exit / result_valid or closes a speed_round window.
module tb_speed_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       speed_right = 1'b0;
  logic       speed_tie = 1'b0;
  logic       speed_round, speed_exit, busy, result_valid;
  logic [3:0] countdown;
  logic [1:0] result;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int run   = 0;

  logic [1:0]  res_q[$];   // expected result per result_valid pulse
  logic [0:0]  exit_q[$];  // expected result_valid per speed_exit pulse
  logic [31:0] len_q[$];   // expected speed_round window length

  speed_round_ctrl #(.TICK_DIV(4), .ARM_TICKS(2), .ROUND_TICKS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .speed_right(speed_right), .speed_tie(speed_tie),
    .speed_round(speed_round), .speed_exit(speed_exit),
    .countdown(countdown), .busy(busy), .result(result),
    .result_valid(result_valid), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        run = 0;
      end else begin
        if (speed_round) begin
          run++;
        end else if (run > 0) begin
          if (len_q.size() == 0) chk("round_len_unexpected", 32'(run), 32'd0);
          else                   chk("round_len", 32'(run), len_q.pop_front());
          run = 0;
        end
        if (speed_exit) begin
          if (exit_q.size() == 0) chk("exit_unexpected", {31'd0, speed_exit}, 32'd0);
          else                    chk("exit_valid", {31'd0, result_valid}, {31'd0, exit_q.pop_front()});
        end else begin
          chk("valid_without_exit", {31'd0, result_valid}, 32'd0);
        end
        if (result_valid) begin
          if (res_q.size() == 0) chk("result_unexpected", {31'd0, result_valid}, 32'd0);
          else                   chk("result", {30'd0, result}, {30'd0, res_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  // Full round: start, ARM (8 cycles), ROUND (12 cycles), 2 SETTLE, DECIDE, EXIT.
  task automatic run_round(input logic r, input logic t, input logic [1:0] exp_res,
                           input logic mid_start);
    speed_right = r;
    speed_tie   = t;
    exit_q.push_back(1'b1);
    res_q.push_back(exp_res);
    len_q.push_back(32'd12);
    start = 1'b1; step(); start = 1'b0;
    chk("arm_cd2", {28'd0, countdown}, 32'd2);
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk("arm_no_round", {31'd0, speed_round}, 32'd0);
    repeat (4) step();
    chk("arm_cd1", {28'd0, countdown}, 32'd1);
    repeat (4) step();
    chk("round_open", {31'd0, speed_round}, 32'd1);
    chk("round_cd3", {28'd0, countdown}, 32'd3);
    repeat (4) step();
    chk("round_cd2", {28'd0, countdown}, 32'd2);
    if (mid_start) begin
      start = 1'b1; step(); start = 1'b0;
      repeat (3) step();
    end else begin
      repeat (4) step();
    end
    chk("round_cd1", {28'd0, countdown}, 32'd1);
    repeat (4) step();
    chk("settle_closed", {31'd0, speed_round}, 32'd0);
    chk("settle_cd0", {28'd0, countdown}, 32'd0);
    repeat (3) step();
    chk("exit_pulse", {31'd0, speed_exit}, 32'd1);
    chk("exit_result", {30'd0, result}, {30'd0, exp_res});
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_exit", {31'd0, speed_exit}, 32'd0);
  endtask

  task automatic run_abort(input logic [1:0] prior);
    speed_right = 1'b1;
    speed_tie   = 1'b0;
    exit_q.push_back(1'b0);
    len_q.push_back(32'd5);
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    chk("abort_round_open", {31'd0, speed_round}, 32'd1);
    repeat (4) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_round_drop", {31'd0, speed_round}, 32'd0);
    chk("abort_exit", {31'd0, speed_exit}, 32'd1);
    chk("abort_result_kept", {30'd0, result}, {30'd0, prior});
    step();
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_exit_once", {31'd0, speed_exit}, 32'd0);
  endtask

`ifdef SPEED_SUDDEN_DEATH_EN
  task automatic run_sudden(input logic second_right, input logic [1:0] exp_res);
    speed_right = 1'b0;
    speed_tie   = 1'b1;
    exit_q.push_back(1'b0);
    exit_q.push_back(1'b1);
    len_q.push_back(32'd12);
    len_q.push_back(32'd12);
    res_q.push_back(exp_res);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 60 && !speed_exit; i++) step();
    chk("sd_first_exit", {31'd0, speed_exit}, 32'd1);
    speed_right = second_right;
    speed_tie   = ~second_right;
    step();
    chk("sd_rerun_round", {31'd0, speed_round}, 32'd1);
    chk("sd_rerun_cd", {28'd0, countdown}, 32'd3);
    chk("sd_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 60 && busy; i++) step();
    chk("sd_done", {31'd0, busy}, 32'd0);
    chk("sd_result", {30'd0, result}, {30'd0, exp_res});
  endtask
`endif

  initial begin
    repeat (3) step();
    rst = 1'b1;
    repeat (20) step();
    chk("rst_round", {31'd0, speed_round}, 32'd0);
    chk("rst_exit", {31'd0, speed_exit}, 32'd0);
    chk("rst_cd", {28'd0, countdown}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {30'd0, result}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);

    run_round(1'b1, 1'b0, 2'b10, 1'b0);
    run_round(1'b0, 1'b0, 2'b01, 1'b0);
    run_abort(2'b01);
`ifdef SPEED_SUDDEN_DEATH_EN
    run_sudden(1'b1, 2'b10);
    run_sudden(1'b0, 2'b11);
`else
    run_round(1'b0, 1'b1, 2'b11, 1'b0);
`endif
    run_round(1'b1, 1'b0, 2'b10, 1'b1);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    repeat (5) step();
    chk("start_abort_idle", {31'd0, busy}, 32'd0);
    chk("start_abort_cd", {28'd0, countdown}, 32'd0);

    // asynchronous reset in the middle of a round
    speed_right = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();
    chk("pre_reset_round", {31'd0, speed_round}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_round", {31'd0, speed_round}, 32'd0);
    chk("async_result", {30'd0, result}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("exit_q_empty", 32'(exit_q.size()), 32'd0);
    chk("len_q_empty", 32'(len_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
